// File: rtl/fm_chfltr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fm_chfltr_ctrl_if
// Output stream between the channel-filter sequencer and the demodulator.
// A sample is transferred in any cycle where valid and ready are both high.
//
// Signals:
//   data[2]  N-bit signed complex sample (0 real, 1 imaginary)
//   valid    data holds an unconsumed sample
//   ready    consumer accepts the sample this cycle
//
// Modports:
//   master   producer side (drives data/valid, samples ready)
//   slave    consumer side (samples data/valid, drives ready)
// ---------------------------------------------------------------------------
interface fm_chfltr_ctrl_if #(
  parameter int N = 12
) ();

  logic signed [N-1:0] data [2];
  logic                valid;
  logic                ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/fm_chfltr_ctrl.sv
// ---------------------------------------------------------------------------
// fm_chfltr_ctrl
// Sequencer for the FM polyphase channel-filter datapath. Owns the decimation
// phase counter, drives the coefficient ROM address, issues the accumulator
// restart strobe and the decimated sample clock, and captures the complex
// filter output into a valid/ready register for the demodulator. The
// decimation ratio can be changed at run time; a new ratio takes effect at
// the next frame boundary (or immediately while idle).
//
// Parameters:
//   N        sample width of the complex filter output
//   CNT_W    phase counter / ROM address width
//   RATIO    decimation ratio after reset (4..2^CNT_W)
//   ROM_LAT  coefficient ROM read latency in cycles (1..4)
//   TAPS     polyphase branches; captures discarded after each start
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   en_i          run request
//   cfg_ratio_i   requested decimation ratio (clamped to 4..2^CNT_W)
//   cfg_load_i    one-cycle pulse, latches cfg_ratio_i as pending
//   addr_o        ROM address (phase count)
//   acc_restart_o accumulators load instead of add; output chain advances
//   clkout_o      decimated sample clock, ~50% duty
//   q_in_i[2]     filter output (0 real, 1 imaginary)
//   running_o     sequencer is in RUN or STOP
//   out_if        output stream (master): data/valid out, ready in
//   ovf_o         sticky overwrite flag     (FM_CHFLTR_CTRL_OVF_EN only)
//   ovf_cnt_o     saturating overwrite count (FM_CHFLTR_CTRL_OVF_EN only)
//
// Build option:
//   FM_CHFLTR_CTRL_OVF_EN  when defined, adds ovf_o / ovf_cnt_o; otherwise an
//                          overwrite of an unconsumed sample is silent.
// ---------------------------------------------------------------------------
module fm_chfltr_ctrl #(
  parameter int N       = 12,
  parameter int CNT_W   = 8,
  parameter int RATIO   = 200,
  parameter int ROM_LAT = 1,
  parameter int TAPS    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic [CNT_W:0]      cfg_ratio_i,
  input  logic                cfg_load_i,
  output logic [CNT_W-1:0]    addr_o,
  output logic                acc_restart_o,
  output logic                clkout_o,
  input  logic signed [N-1:0] q_in_i [2],
  output logic                running_o,
`ifdef FM_CHFLTR_CTRL_OVF_EN
  output logic                ovf_o,
  output logic [15:0]         ovf_cnt_o,
`endif
  fm_chfltr_ctrl_if.master    out_if
);

  localparam int RW        = CNT_W + 1;
  localparam int MIN_RATIO = 4;
  localparam int MAX_RATIO = 1 << CNT_W;
  localparam int FILL_W    = $clog2(TAPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    addr_q;
  logic [RW-1:0]       activeRatio_q;
  logic [RW-1:0]       pending_q;
  logic                pendingValid_q;
  logic                clkout_q;
  logic                running_q;
  logic [ROM_LAT:0]    token_q;
  logic                capture_q;
  logic [FILL_W-1:0]   fillCnt_q;
  logic signed [N-1:0] data_q [2];
  logic                valid_q;

  logic                atZero;
  logic                counting;
  logic                frameEnd;
  logic                applyPending;
  logic [RW-1:0]       nextRatio;
  logic                halfHit;
  logic                startRun;
  logic                keep;

  function automatic logic [RW-1:0] clampRatio(input logic [RW-1:0] r);
    if (r < RW'(MIN_RATIO)) begin
      return RW'(MIN_RATIO);
    end else if (r > RW'(MAX_RATIO)) begin
      return RW'(MAX_RATIO);
    end else begin
      return r;
    end
  endfunction

  // A frame ends on the addr==0 cycle while counting. A pending ratio is
  // taken at that boundary, or straight away when the sequencer is idle,
  // so the following reload already uses the new value.
  assign atZero       = (addr_q == '0);
  assign counting     = (state_q != IDLE);
  assign frameEnd     = counting && atZero;
  assign applyPending = pendingValid_q && (!counting || atZero);
  assign nextRatio    = applyPending ? pending_q : activeRatio_q;
  assign halfHit      = counting && ({1'b0, addr_q} == (activeRatio_q >> 1));
  assign startRun     = (state_q == IDLE) && (state_d == RUN);

  // STOP keeps counting so the frame in progress completes; raising en
  // again before the boundary resumes RUN without touching the phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en_i) state_d = RUN;
      RUN:  if (!en_i) state_d = STOP;
      STOP: begin
        if (en_i) begin
          state_d = RUN;
        end else if (atZero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer: state, phase counter, ratio bookkeeping and the registered
  // status outputs. clkout rises after each frame end and falls after the
  // mid-frame count, and is held low whenever the sequencer is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= CNT_W'(RATIO - 1);
      activeRatio_q  <= RW'(RATIO);
      pending_q      <= RW'(RATIO);
      pendingValid_q <= 1'b0;
      clkout_q       <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d != IDLE);

      if (!counting || atZero) begin
        addr_q <= CNT_W'(nextRatio - RW'(1));
      end else begin
        addr_q <= addr_q - CNT_W'(1);
      end

      activeRatio_q <= nextRatio;

      // A load coinciding with an apply becomes the next pending value.
      if (cfg_load_i) begin
        pending_q      <= clampRatio(cfg_ratio_i);
        pendingValid_q <= 1'b1;
      end else if (applyPending) begin
        pendingValid_q <= 1'b0;
      end

      if (state_d == IDLE) begin
        clkout_q <= 1'b0;
      end else if (frameEnd) begin
        clkout_q <= 1'b1;
      end else if (halfHit) begin
        clkout_q <= 1'b0;
      end
    end
  end

  // Strobe pipeline: a frame-end token travels ROM_LAT+1 stages to become
  // acc_restart, then one more stage to mark the cycle whose q_in is
  // captured. Tokens already launched complete even after returning to
  // IDLE; only reset flushes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      token_q   <= '0;
      capture_q <= 1'b0;
    end else begin
      token_q   <= {token_q[ROM_LAT-1:0], frameEnd};
      capture_q <= token_q[ROM_LAT];
    end
  end

  // The first TAPS captures after each start only contain a partially
  // filled output chain, so they are counted and thrown away.
  assign keep = capture_q && (fillCnt_q == FILL_W'(TAPS));

  always_ff @(posedge clk) begin
    if (reset) begin
      fillCnt_q <= '0;
    end else if (startRun) begin
      fillCnt_q <= '0;
    end else if (capture_q && (fillCnt_q != FILL_W'(TAPS))) begin
      fillCnt_q <= fillCnt_q + FILL_W'(1);
    end
  end

  // Output register: a kept capture always loads and (re)asserts valid,
  // overwriting an unconsumed sample if the consumer is stalled. A
  // handshake without a capture empties the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      valid_q   <= 1'b0;
    end else if (keep) begin
      data_q[0] <= q_in_i[0];
      data_q[1] <= q_in_i[1];
      valid_q   <= 1'b1;
    end else if (valid_q && out_if.ready) begin
      valid_q   <= 1'b0;
    end
  end

`ifdef FM_CHFLTR_CTRL_OVF_EN
  logic        overwrite;
  logic        ovf_q;
  logic [15:0] ovfCnt_q;

  assign overwrite = keep && valid_q && !out_if.ready;

  // Sticky overflow flag and saturating count of lost samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q    <= 1'b0;
      ovfCnt_q <= '0;
    end else if (overwrite) begin
      ovf_q <= 1'b1;
      if (ovfCnt_q != 16'hFFFF) begin
        ovfCnt_q <= ovfCnt_q + 16'd1;
      end
    end
  end

  assign ovf_o     = ovf_q;
  assign ovf_cnt_o = ovfCnt_q;
`endif

  assign addr_o         = addr_q;
  assign acc_restart_o  = token_q[ROM_LAT];
  assign clkout_o       = clkout_q;
  assign running_o      = running_q;
  assign out_if.data[0] = data_q[0];
  assign out_if.data[1] = data_q[1];
  assign out_if.valid   = valid_q;

endmodule
